// File: rtl/debug_unit_rx_loader_if.sv
// rtl/debug_unit_rx_loader_if.sv - byte stream in, memory write and run control out
interface debug_unit_rx_loader_if #(
  parameter int N_BITS       = 8,
  parameter int N_BITS_INSTR = 32,
  parameter int N_BITS_ADDR  = 8,
  parameter int NB_STATE     = 3
);
  logic [N_BITS-1:0]       i_rx_data;
  logic                    i_rx_done;
  logic                    o_write_enable;
  logic [N_BITS_ADDR-1:0]  o_write_addr;
  logic [N_BITS_INSTR-1:0] o_write_data;
  logic                    o_load_done;
  logic                    o_execution_mode;
  logic                    o_execution_step;
  logic                    o_load_error;
  logic [NB_STATE-1:0]     o_state;

  modport master (
    output i_rx_data, i_rx_done,
    input  o_write_enable, o_write_addr, o_write_data, o_load_done,
    input  o_execution_mode, o_execution_step, o_load_error, o_state
  );

  modport slave (
    input  i_rx_data, i_rx_done,
    output o_write_enable, o_write_addr, o_write_data, o_load_done,
    output o_execution_mode, o_execution_step, o_load_error, o_state
  );
endinterface

// File: rtl/debug_unit_rx_loader.sv
// rtl/debug_unit_rx_loader.sv - UART byte-stream loader/run control; DEBUG_RX_CHECKSUM_EN adds XOR load checksum
module debug_unit_rx_loader #(
  parameter int                N_BITS       = 8,
  parameter int                N_BITS_INSTR = 32,
  parameter int                N_BITS_ADDR  = 8,
  parameter logic [N_BITS-1:0] CMD_LOAD     = 'h55,
  parameter logic [N_BITS-1:0] CMD_STEP     = 'h53,
  parameter int                NB_STATE     = 3
) (
  input logic                   i_clock,
  input logic                   i_reset,
  debug_unit_rx_loader_if.slave bus
);
  localparam int BYTES = N_BITS_INSTR / N_BITS;
  localparam int CNT_W = $clog2(BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);
  localparam int PART_W = N_BITS_INSTR - N_BITS;

  typedef enum logic [NB_STATE-1:0] {
    IDLE  = NB_STATE'(0),
    LOAD  = NB_STATE'(1),
    CHECK = NB_STATE'(2),
    MODE  = NB_STATE'(3),
    RUN   = NB_STATE'(4),
    ERROR = NB_STATE'(5)
  } state_t;

  state_t                  state_q;
  logic [PART_W-1:0]       part_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [N_BITS_ADDR-1:0]  addr_q;
  logic [N_BITS_ADDR-1:0]  waddr_q;
  logic [N_BITS_INSTR-1:0] wdata_q;
  logic                    we_q;
  logic                    step_q;
  logic                    mode_q;
  logic                    done_q;
  logic [N_BITS_INSTR-1:0] word_d;
  logic                    halt_d;
`ifdef DEBUG_RX_CHECKSUM_EN
  logic [N_BITS-1:0]       xsum_q;
  logic                    err_q;
`endif

  // Only the leading BYTES-1 bytes are stored; the last byte completes the word combinationally.
  always_comb begin
    word_d = {part_q, bus.i_rx_data};
    halt_d = (word_d == {N_BITS_INSTR{1'b1}});
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      part_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      step_q  <= 1'b0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DEBUG_RX_CHECKSUM_EN
      xsum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      we_q    <= 1'b0;
      wdata_q <= '0;
      step_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.i_rx_done && bus.i_rx_data == CMD_LOAD) begin
            state_q <= LOAD;
            part_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
`ifdef DEBUG_RX_CHECKSUM_EN
            xsum_q  <= '0;
`endif
          end
        end
        LOAD: begin
          if (bus.i_rx_done) begin
            part_q <= word_d[PART_W-1:0];
`ifdef DEBUG_RX_CHECKSUM_EN
            xsum_q <= xsum_q ^ bus.i_rx_data;
`endif
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              we_q    <= 1'b1;
              waddr_q <= addr_q;
              wdata_q <= word_d;
              addr_q  <= addr_q + 1'b1;
              if (halt_d) begin
`ifdef DEBUG_RX_CHECKSUM_EN
                state_q <= CHECK;
`else
                state_q <= MODE;
                done_q  <= 1'b1;
`endif
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
`ifdef DEBUG_RX_CHECKSUM_EN
        CHECK: begin
          if (bus.i_rx_done) begin
            if (bus.i_rx_data == xsum_q) begin
              state_q <= MODE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ERROR;
              err_q   <= 1'b1;
            end
          end
        end
        ERROR: begin
          state_q <= ERROR;
        end
`endif
        MODE: begin
          if (bus.i_rx_done) begin
            mode_q  <= bus.i_rx_data[0];
            state_q <= RUN;
          end
        end
        RUN: begin
          if (bus.i_rx_done && mode_q && bus.i_rx_data == CMD_STEP) begin
            step_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_write_enable   = we_q;
  assign bus.o_write_addr     = waddr_q;
  assign bus.o_write_data     = wdata_q;
  assign bus.o_load_done      = done_q;
  assign bus.o_execution_mode = mode_q;
  assign bus.o_execution_step = step_q;
  assign bus.o_state          = state_q;
`ifdef DEBUG_RX_CHECKSUM_EN
  assign bus.o_load_error     = err_q;
`else
  assign bus.o_load_error     = 1'b0;
`endif
endmodule

// File: tb/tb_debug_unit_rx_loader.sv
// tb/tb_debug_unit_rx_loader.sv - randomized bench for debug_unit_rx_loader against a stream-level model
module tb_debug_unit_rx_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debug_unit_rx_loader_if #(.N_BITS(8), .N_BITS_INSTR(32), .N_BITS_ADDR(8), .NB_STATE(3)) bus_a ();
  debug_unit_rx_loader_if #(.N_BITS(8), .N_BITS_INSTR(32), .N_BITS_ADDR(2), .NB_STATE(3)) bus_b ();

  debug_unit_rx_loader #(.N_BITS_ADDR(8)) dut_a (.i_clock(clk), .i_reset(rst), .bus(bus_a.slave));
  debug_unit_rx_loader #(.N_BITS_ADDR(2)) dut_b (.i_clock(clk), .i_reset(rst), .bus(bus_b.slave));

  int n_checks = 0;
  int n_fail   = 0;
  int steps_seen;

  // Reference model: phase follows the documented state numbers, word bytes kept in a queue.
  int          m_ph;
  logic [7:0]  m_q[$];
  int          m_addr;
  logic [7:0]  m_x;
  bit          m_mode;
  bit          e_we;
  int          e_wa;
  logic [31:0] e_wd;
  bit          e_step;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_ph = 0; m_q.delete(); m_addr = 0; m_x = 8'h00; m_mode = 1'b0;
    e_we = 1'b0; e_wa = 0; e_wd = 32'h0; e_step = 1'b0;
  endfunction

  function automatic void model_step(bit v, logic [7:0] b);
    logic [31:0] w;
    e_we = 1'b0; e_wd = 32'h0; e_step = 1'b0;
    if (v) begin
      case (m_ph)
        0: if (b == 8'h55) begin m_ph = 1; m_q.delete(); m_addr = 0; m_x = 8'h00; end
        1: begin
          m_q.push_back(b);
          m_x = m_x ^ b;
          if (m_q.size() == 4) begin
            w = {m_q[0], m_q[1], m_q[2], m_q[3]};
            e_we = 1'b1; e_wa = m_addr; e_wd = w;
            m_addr = (m_addr + 1) % 256;
            m_q.delete();
`ifdef DEBUG_RX_CHECKSUM_EN
            if (w == 32'hFFFF_FFFF) m_ph = 2;
`else
            if (w == 32'hFFFF_FFFF) m_ph = 3;
`endif
          end
        end
        2: m_ph = (b == m_x) ? 3 : 5;
        3: begin m_mode = b[0]; m_ph = 4; end
        4: if (m_mode && b == 8'h53) e_step = 1'b1;
        default: ;
      endcase
    end
  endfunction

  task automatic compare_all();
    check("we_a", bus_a.o_write_enable, e_we);
    check("we_b", bus_b.o_write_enable, e_we);
    if (e_we) begin
      check("waddr_a", bus_a.o_write_addr, e_wa);
      check("waddr_b", bus_b.o_write_addr, e_wa % 4);
    end
    check("wdata_a", bus_a.o_write_data, e_wd);
    check("wdata_b", bus_b.o_write_data, e_wd);
    check("step", bus_a.o_execution_step, e_step);
    check("mode", bus_a.o_execution_mode, m_mode);
    check("load_done", bus_a.o_load_done, (m_ph == 3 || m_ph == 4));
    check("load_error", bus_a.o_load_error, (m_ph == 5));
    check("state_a", bus_a.o_state, m_ph);
    check("state_b", bus_b.o_state, m_ph);
    steps_seen += int'(bus_a.o_execution_step);
  endtask

  task automatic drive(bit v, logic [7:0] b);
    bus_a.i_rx_done = v; bus_a.i_rx_data = b;
    bus_b.i_rx_done = v; bus_b.i_rx_data = b;
  endtask

  task automatic tick(bit v, logic [7:0] b);
    drive(v, b);
    @(posedge clk);
    #1;
    model_step(v, b);
    compare_all();
  endtask

  task automatic send(logic [7:0] b, int gap);
    repeat (gap) tick(1'b0, 8'($urandom));
    tick(1'b1, b);
  endtask

  task automatic send_word(logic [31:0] w, int gap);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8], gap);
  endtask

  // Reset is asserted together with a CMD_LOAD byte to show reset wins.
  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 8'h55);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    compare_all();
    check("rst_waddr_a", bus_a.o_write_addr, 0);
    check("rst_waddr_b", bus_b.o_write_addr, 0);
  endtask

  task automatic send_checksum(bit good);
`ifdef DEBUG_RX_CHECKSUM_EN
    send(good ? m_x : (m_x ^ 8'h01), 0);
`endif
  endtask

  initial begin
    drive(1'b0, 8'h00);
    model_reset();
    do_reset();

    // Load then step mode, with idle junk first
    send(8'h00, 0); send(8'h00, 1);
    send(8'h55, 0);
    send_word(32'h1234_5678, 0);
    send_word(32'hFFFF_FFFF, 0);
    send_checksum(1'b1);
    check("loaded_state", bus_a.o_state, 3);
    send(8'h01, 0);
    steps_seen = 0;
    send(8'h53, 0); send(8'h53, 0); send(8'h00, 0); send(8'h53, 0);
    tick(1'b0, 8'h00);
    check("step_count", steps_seen, 3);

    // Continuous mode ignores steps
    do_reset();
    send(8'h55, 0); send_word(32'h1234_5678, 0); send_word(32'hFFFF_FFFF, 0);
    send_checksum(1'b1);
    send(8'h00, 0);
    steps_seen = 0;
    send(8'h53, 0);
    check("cont_no_step", steps_seen, 0);
    check("cont_state", bus_a.o_state, 4);

`ifdef DEBUG_RX_CHECKSUM_EN
    do_reset();
    send(8'h55, 0); send_word(32'h1234_5678, 0); send_word(32'hFFFF_FFFF, 0);
    check("cks_expected", m_x, 8'h08);
    send(8'h09, 0);
    send(8'h01, 0); send(8'h53, 0);
    check("cks_err_state", bus_a.o_state, 5);
    check("cks_err_flag", bus_a.o_load_error, 1);
`endif

    // Reset mid-load, then restart at address 0
    do_reset();
    send(8'h55, 0); send(8'h12, 0); send(8'h34, 0);
    do_reset();
    send(8'h55, 0); send_word(32'hAABB_CCDD, 0);
    tick(1'b0, 8'h00);

    // Address wrap on the 2-bit instance
    do_reset();
    send(8'h00, 0); send(8'h55, 0);
    for (int i = 0; i < 5; i++) send_word(32'h0102_0300 + 32'(i), 0);

    // Randomized sessions
    for (int it = 0; it < 8; it++) begin
      do_reset();
      repeat ($urandom_range(0, 3)) send(8'($urandom_range(0, 8'h54)), $urandom_range(0, 2));
      send(8'h55, $urandom_range(0, 2));
      repeat ($urandom_range(1, 6)) send_word($urandom, $urandom_range(0, 2));
      send_word(32'hFFFF_FFFF, $urandom_range(0, 1));
      send_checksum(($urandom % 4) != 0);
      send(8'($urandom), $urandom_range(0, 2));
      repeat (20) send(($urandom % 2) ? 8'h53 : 8'($urandom), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/debug_unit_rx_loader.md
# debug_unit_rx_loader

Parametrised byte-stream front end of the debug unit, sitting between the UART receiver and the instruction memory / pipeline control. It decodes a framed command stream into three actions: instruction words to write, an execution-mode selection, and single-step strobes. Compared with the fixed 32-bit loader, it adds:
- configurable word and address widths;
- an explicit write address;
- configurable command bytes;
- an optional load checksum with a sticky error state.

## Interface
- N_BITS, 8: UART byte width.
- N_BITS_INSTR, 32: instruction word width; must be an integer multiple of N_BITS, at least 2×N_BITS. BYTES = N_BITS_INSTR/N_BITS.
- N_BITS_ADDR, 8: instruction memory address width.
- CMD_LOAD, 8'h55: byte that starts a program load.
- CMD_STEP, 8'h53: byte that requests one step in step mode.
- NB_STATE, 3: state register width.

Ports (synchronous active-high reset; all logic on posedge i_clock):
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  N_BITS  received byte; valid only while i_rx_done=1.
- i_rx_done  in  1  one-cycle strobe per received byte; may be high on consecutive cycles.
- o_write_enable  out  1  one-cycle instruction memory write pulse.
- o_write_addr  out  N_BITS_ADDR  write address; valid while o_write_enable=1.
- o_write_data  out  N_BITS_INSTR  assembled word; zero when o_write_enable=0.
- o_load_done  out  1  level; program fully loaded (and checksum passed, when enabled).
- o_execution_mode  out  1  latched mode: 1 = step-by-step, 0 = continuous.
- o_execution_step  out  1  one-cycle step pulse.
- o_load_error  out  1  sticky checksum error; tied 0 when checksum is compiled out.
- o_state  out  NB_STATE  current FSM state, for debug.

## Operation
- State encoding: IDLE=0, LOAD=1, CHECK=2, MODE=3, RUN=4, ERROR=5. Any other encoding → IDLE on the next cycle.
- IDLE: a byte equal to CMD_LOAD → LOAD; the byte counter, write address and checksum are cleared. All other bytes are ignored.
- LOAD: each byte shifts into the word register MSB-first (first byte received = most significant byte). The byte counter runs 0..BYTES-1.
  - On the BYTES-th byte, the complete word is written at the current address, then the address increments.
  - The address wraps modulo 2^N_BITS_ADDR; there is no overflow error.
  - Halt detection applies to the whole assembled word only. A word of all ones (HALT) is written like any other word, then the FSM moves to CHECK (checksum compiled in) or MODE (compiled out).
  - Individual 0xFF bytes inside a non-halt word have no special meaning.
- CHECK: the next byte is compared with the XOR of every byte received in LOAD, including the HALT bytes.
  - Equal → MODE.
  - Different → ERROR.
- MODE: o_load_done=1 from entry to MODE until reset. The next byte sets o_execution_mode ← bit 0 of that byte, then → RUN.
- RUN: o_execution_mode is held.
  - Step mode: each byte equal to CMD_STEP produces one o_execution_step pulse; other bytes are ignored.
  - Continuous mode: all bytes are ignored.
  - RUN is left only by reset.
- ERROR: o_load_error=1 and o_load_done=0. All bytes are ignored; ERROR is left only by reset.

## Timing
- Reset values: state=IDLE and all outputs 0, including o_write_addr and o_write_data. Reset clears the partial word, the byte counter, the address, the checksum and the mode.
- All outputs are registered. State changes on the edge where i_rx_done=1 is sampled.
- Write latency: o_write_enable is high for exactly one cycle, the cycle after the last byte of a word is sampled. o_write_addr and o_write_data are stable in that cycle.
- Step latency: o_execution_step is high for exactly one cycle, the cycle after a CMD_STEP byte is sampled. Back-to-back CMD_STEP bytes on consecutive cycles give back-to-back pulses.
- o_execution_mode and o_load_done update one cycle after the triggering byte.
- Reset mid-operation: reset overrides everything in the same cycle. A pending write pulse is suppressed, and the next load starts at address 0.
- No back-pressure: the memory must accept one write per BYTES received bytes.

## Configuration
- DEBUG_RX_CHECKSUM_EN defined: the CHECK state and XOR accumulator are compiled in, and o_load_error is driven as described above.
- DEBUG_RX_CHECKSUM_EN undefined: the HALT word goes LOAD → MODE directly. CHECK and ERROR are unreachable, and o_load_error is constant 0.

## Test plan
- Load, defaults, no checksum: 55, 12 34 56 78, FF FF FF FF → write pulses at (addr 0, 0x12345678) and (addr 1, 0xFFFFFFFF); o_load_done=1; o_state=3.
- Step mode: after the load, send 01, then 53 53 00 53 → o_execution_mode=1; exactly three o_execution_step pulses, each one cycle after its 53 byte.
- Continuous mode: after the load, send 00, then 53 → o_execution_mode=0; no step pulse; o_state=4.
- Checksum (DEBUG_RX_CHECKSUM_EN): load stream as in the first scenario.
  - Checksum byte 08 → MODE, o_load_done=1.
  - Checksum byte 09 → ERROR (o_state=5), o_load_error=1, and subsequent 01 53 are ignored.
- Reset mid-load: 55 12 34, then i_reset for one cycle → no write, all outputs 0. Then 55 AA BB CC DD → write at addr 0, data 0xAABBCCDD.
- Wrap, N_BITS_ADDR=2: 55 followed by five non-halt words → the fifth word is written at addr 0. 00 bytes before 55 in IDLE produce no activity.
